// File: rtl/alu_serial_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : op codes, FSM encoding and default width for alu_serial_seq
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 24;

    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT = 4'b0111;
    localparam logic [3:0] ALU_OP_NOR = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_serial_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_serial_seq_if : upstream operand and downstream result handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_serial_seq_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       AluOp;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Negative;
    logic             CarryOut;
    logic             Overflow;
    logic             Busy;

    modport slave (
        input  InValid, A, B, AluOp, OutReady,
        output InReady, OutValid, Result, Zero, Negative, CarryOut, Overflow, Busy
    );

    modport master (
        output InValid, A, B, AluOp, OutReady,
        input  InReady, OutValid, Result, Zero, Negative, CarryOut, Overflow, Busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_seq_alu_1bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ALU_1bit : single ALU slice (AND / OR / full-add / LESS pass-through)
// Rev 1.0
// ---------------------------------------------------------------------------
module ALU_1bit (
    input  wire logic       a_i,
    input  wire logic       b_i,
    input  wire logic       ainvert_i,
    input  wire logic       binvert_i,
    input  wire logic       carry_i,
    input  wire logic       less_i,
    input  wire logic [1:0] operation_i,
    output logic            result_o,
    output logic            carry_o
);
    logic w_a;
    logic w_b;

    assign w_a     = a_i ^ ainvert_i;
    assign w_b     = b_i ^ binvert_i;
    assign carry_o = (w_a & w_b) | (w_a & carry_i) | (w_b & carry_i);

    always_comb begin
        result_o = 1'b0;
        case (operation_i)
            2'b00:   result_o = w_a & w_b;
            2'b01:   result_o = w_a | w_b;
            2'b10:   result_o = w_a ^ w_b ^ carry_i;
            default: result_o = less_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_serial_seq : bit-serial ALU stage, one ALU_1bit slice reused LSB first
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic Clock,
    input  wire logic ResetN,
    alu_serial_seq_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             w_slice_res;
    logic             w_slice_cout;
    logic [1:0]       w_slice_op;
    logic             w_last;
    logic             w_is_slt;
    logic             w_ovf;
    logic             w_less;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_final;

    // SLT runs through the slice as a plain subtract; the fix-up happens at the MSB
    assign w_is_slt   = (op_q[1:0] == 2'b11);
    assign w_slice_op = w_is_slt ? 2'b10 : op_q[1:0];
    assign w_last     = (cnt_q == CNT_W'(WIDTH - 1));
    assign w_r_next   = {w_slice_res, r_sh_q[WIDTH-1:1]};
    assign w_ovf      = carry_q ^ w_slice_cout;
    assign w_less     = w_slice_res ^ w_ovf;
    assign w_final    = w_is_slt ? {{(WIDTH-1){1'b0}}, w_less} : w_r_next;

    ALU_1bit u_slice (
        .a_i         (a_sh_q[0]),
        .b_i         (b_sh_q[0]),
        .ainvert_i   (op_q[3]),
        .binvert_i   (op_q[2]),
        .carry_i     (carry_q),
        .less_i      (1'b0),
        .operation_i (w_slice_op),
        .result_o    (w_slice_res),
        .carry_o     (w_slice_cout)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.InValid)  state_d = ST_BUSY;
            ST_BUSY: if (w_last)       state_d = ST_DONE;
            ST_DONE: if (bus.OutReady) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.InReady  = (state_q == ST_IDLE);
        bus.OutValid = (state_q == ST_DONE);
        bus.Busy     = (state_q == ST_BUSY);
    end

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (state_q == ST_IDLE && bus.InValid) begin
            a_sh_d  = bus.A;
            b_sh_d  = bus.B;
            op_d    = bus.AluOp;
            carry_d = bus.AluOp[2];
            cnt_d   = '0;
            r_sh_d  = '0;
        end else if (state_q == ST_BUSY) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            r_sh_d  = w_r_next;
            carry_d = w_slice_cout;
            if (w_last) begin
                // carry_q here is the carry into the MSB
                result_d = w_final;
                zero_d   = (w_final == '0);
                neg_d    = w_final[WIDTH-1];
                cout_d   = op_q[1] & w_slice_cout;
                ovf_d    = op_q[1] & w_ovf;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.Result   = result_q;
    assign bus.Zero     = zero_q;
    assign bus.Negative = neg_q;
    assign bus.CarryOut = cout_q;
    assign bus.Overflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_serial_seq : directed self-checking bench for alu_serial_seq
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_serial_seq;
    import alu_pkg::*;

    logic Clock;
    logic ResetN;
    int   passed;
    int   total;

    alu_serial_seq_if bus ();

    alu_serial_seq u_dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] outs();
        return {bus.Result, bus.Zero, bus.Negative, bus.CarryOut, bus.Overflow};
    endfunction

    // Issue one op and wait (bounded) for OutValid; lat counts edges from the accept edge inclusive.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                          output int lat);
        int n;
        bus.A = a; bus.B = b; bus.AluOp = op; bus.InValid = 1'b1;
        n = 0;
        while (!bus.InReady && n < 100) begin @(posedge Clock); #1; n++; end
        @(posedge Clock); #1;
        bus.InValid = 1'b0; bus.A = ~a; bus.B = ~b; bus.AluOp = ~op;
        lat = 1;
        while (!bus.OutValid && lat < 100) begin @(posedge Clock); #1; lat++; end
        if (!bus.OutValid) begin
            total++;
            $display("FAIL op_timeout: OutValid=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0; bus.InValid = 1'b0; bus.OutReady = 1'b1;
        bus.A = '0; bus.B = '0; bus.AluOp = '0;
        repeat (2) @(posedge Clock);
        #1;
        total++;
        if ({outs(), bus.OutValid, bus.Busy, bus.InReady} !== {28'h0, 3'b001})
            $display("FAIL reset_state: got %h, required %h",
                     {outs(), bus.OutValid, bus.Busy, bus.InReady}, {28'h0, 3'b001});
        else passed++;
        ResetN = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_add();
        int lat;
        bus.OutReady = 1'b1;
        run_op(24'h000001, 24'hFFFFFF, ALU_OP_ADD, lat);
        total++;
        if (lat !== 25) $display("FAIL add_latency: got %0d, required 25", lat);
        else passed++;
        total++;
        if (outs() !== {24'h000000, 4'b1010})
            $display("FAIL add_result: got %h, required %h", outs(), {24'h000000, 4'b1010});
        else passed++;
        @(posedge Clock); #1;
        total++;
        if ({bus.OutValid, bus.InReady, bus.Result} !== {2'b01, 24'h000000})
            $display("FAIL add_handshake: got %h, required %h",
                     {bus.OutValid, bus.InReady, bus.Result}, {2'b01, 24'h000000});
        else passed++;
    endtask

    task automatic test_sub();
        int lat;
        run_op(24'h7FFFFF, 24'hFFFFFF, ALU_OP_SUB, lat);
        total++;
        if (outs() !== {24'h800000, 4'b0101})
            $display("FAIL sub_result: got %h, required %h", outs(), {24'h800000, 4'b0101});
        else passed++;
        @(posedge Clock); #1;
    endtask

    task automatic test_slt();
        logic [23:0] va [3] = '{24'hFFFFFF, 24'h800000, 24'h000005};
        logic [23:0] vb [3] = '{24'h000001, 24'h7FFFFF, 24'h000003};
        logic [27:0] ve [3] = '{{24'h000001, 4'b0010}, {24'h000001, 4'b0011},
                                {24'h000000, 4'b1010}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], ALU_OP_SLT, lat);
            total++;
            if (outs() !== ve[i])
                $display("FAIL slt_%0d: got %h, required %h", i, outs(), ve[i]);
            else passed++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_logic();
        logic [3:0]  vo [3] = '{ALU_OP_NOR, ALU_OP_OR, ALU_OP_AND};
        logic [27:0] ve [3] = '{{24'hF000F0, 4'b0100}, {24'h0FFF0F, 4'b0000},
                                {24'h000F00, 4'b0000}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(24'h0F0F0F, 24'h00FF00, vo[i], lat);
            total++;
            if (outs() !== ve[i])
                $display("FAIL logic_%0d: got %h, required %h", i, outs(), ve[i]);
            else passed++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        int n;
        bus.OutReady = 1'b0;
        run_op(24'h123456, 24'h111111, ALU_OP_ADD, lat);
        total++;
        if (outs() !== {24'h234567, 4'b0000})
            $display("FAIL bp_result: got %h, required %h", outs(), {24'h234567, 4'b0000});
        else passed++;
        bus.A = 24'h000005; bus.B = 24'h000003; bus.AluOp = ALU_OP_SUB; bus.InValid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock); #1;
            if ({bus.OutValid, bus.InReady, outs()} !== {2'b10, 24'h234567, 4'b0000}) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles, required 0", bad);
        else passed++;
        bus.OutReady = 1'b1;
        @(posedge Clock); #1;
        total++;
        if ({bus.OutValid, bus.InReady, bus.Busy, bus.Result} !== {3'b010, 24'h234567})
            $display("FAIL bp_release: got %h, required %h",
                     {bus.OutValid, bus.InReady, bus.Busy, bus.Result}, {3'b010, 24'h234567});
        else passed++;
        @(posedge Clock); #1;
        bus.InValid = 1'b0;
        total++;
        if ({bus.Busy, bus.InReady} !== 2'b10)
            $display("FAIL bp_next_accept: got %b, required 10", {bus.Busy, bus.InReady});
        else passed++;
        n = 0;
        while (!bus.OutValid && n < 100) begin @(posedge Clock); #1; n++; end
        total++;
        if (outs() !== {24'h000002, 4'b0010})
            $display("FAIL bp_second_op: got %h, required %h", outs(), {24'h000002, 4'b0010});
        else passed++;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.OutReady = 1'b1;
        bus.A = 24'hFFFFFF; bus.B = 24'hFFFFFF; bus.AluOp = ALU_OP_ADD; bus.InValid = 1'b1;
        @(posedge Clock); #1;
        bus.InValid = 1'b0;
        repeat (12) @(posedge Clock);
        #1;
        total++;
        if (bus.Busy !== 1'b1) $display("FAIL mid_busy: got %b, required 1", bus.Busy);
        else passed++;
        #2 ResetN = 1'b0;
        #1;
        total++;
        if ({outs(), bus.OutValid, bus.Busy, bus.InReady} !== {28'h0, 3'b001})
            $display("FAIL mid_reset_state: got %h, required %h",
                     {outs(), bus.OutValid, bus.Busy, bus.InReady}, {28'h0, 3'b001});
        else passed++;
        @(posedge Clock); #1;
        ResetN = 1'b1;
        run_op(24'h000003, 24'h000004, ALU_OP_ADD, lat);
        total++;
        if ({lat[7:0], outs()} !== {8'd25, 24'h000007, 4'b0000})
            $display("FAIL post_reset_add: got %h, required %h",
                     {lat[7:0], outs()}, {8'd25, 24'h000007, 4'b0000});
        else passed++;
        @(posedge Clock); #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Bit-serial ALU execution stage that time-multiplexes one ALU_1bit slice across a WIDTH-bit word, LSB first, one bit per clock.
- Sits between operand fetch (upstream valid/ready) and writeback (downstream valid/ready).
- It is a small-area alternative to the 24-slice ripple ALU.
- It owns operand shift registers, the carry flop, the bit counter, the SLT fix-up and the flag generation.

Parameters:
WIDTH, 24, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-counter width

Ports:
Clock  input  1  single clock, rising edge
ResetN  input  1  asynchronous, active-low reset
InValid  input  1  upstream operands/op valid
InReady  output  1  block can accept (high only in IDLE)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
AluOp  input  4  {AInvert, BInvert, Operation[1:0]}: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
OutValid  output  1  result/flags valid (DONE)
OutReady  input  1  downstream accepts
Result  output  WIDTH  final result
Zero  output  1  Result == 0
Negative  output  1  Result[WIDTH-1]
CarryOut  output  1  carry out of MSB (ADD/SUB/SLT pass)
Overflow  output  1  signed overflow of the add pass
Busy  output  1  state == BUSY

Behaviour:
- Clock and reset: one clock, Clock. Reset is asynchronous, active-low, on ResetN.
- Reset (ResetN=0): state=IDLE, counter=0, carry=0, shift regs=0. Result, all flags, OutValid and Busy are 0. InReady=1.
- IDLE: on InValid&&InReady, latch A, B, AluOp into shift regs.
  - carry <= AluOp[2] (BInvert doubles as CarryIn for bit 0).
  - counter <= 0, then go to BUSY.
- BUSY, one bit per cycle:
  - Slice inputs are A_sh[0], B_sh[0], AInvert, BInvert and carry.
  - Slice Operation is AluOp[1:0], forced to 10 when AluOp[1:0]==11 (SLT runs as a subtract pass).
  - Slice LESS input is tied 0.
  - Each cycle: A_sh/B_sh shift right; the slice Result shifts into R_sh[WIDTH-1]; carry <= COUT.
  - When counter==WIDTH-1, capture cin_msb <= carry (the carry into the MSB), then go to DONE.
  - Otherwise counter++.
- BUSY to DONE update, registered on the final edge:
  - Result = R_sh, or {0..0, less} for SLT, where less = sum_msb XOR (cin_msb XOR cout_msb).
  - CarryOut = cout_msb. Overflow = cin_msb XOR cout_msb.
  - For AND/OR/NOR, CarryOut and Overflow are 0.
  - Zero and Negative are derived from the final Result.
- DONE: OutValid=1. Result and flags are held stable while OutReady=0. On OutReady, go to IDLE; outputs keep their last values, OutValid drops.
- Latency and throughput:
  - Accept edge, then WIDTH BUSY cycles; OutValid rises WIDTH+1 cycles after the accept edge.
  - At most one op per WIDTH+2 cycles.
  - No accept in DONE or BUSY, even if OutReady and InValid arrive together.
- Input stability: A, B and AluOp may change freely after the accept edge.
- Reset mid-operation: ResetN low in BUSY or DONE aborts immediately to the reset state. No OutValid is produced for the aborted op.
- Unlisted AluOp codes: bits are applied raw to the slice. Only Operation==11 triggers the SLT fix-up. No error flag.

Decomposition:
- Package alu_pkg:
  - ALU_OP_AND/OR/ADD/SUB/SLT/NOR 4-bit constants.
  - State encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Default WIDTH=24.
- One sub-module: instantiate the existing ALU_1bit as the datapath slice. The FSM, counter and shift registers stay in alu_serial_seq.

Test Plan:
- ADD A=0x000001, B=0xFFFFFF, OutReady=1 -> OutValid exactly 25 cycles after accept; Result=0x000000, Zero=1, CarryOut=1, Overflow=0.
- SUB A=0x7FFFFF, B=0xFFFFFF -> Result=0x800000, Negative=1, Overflow=1.
- SLT: A=0xFFFFFF, B=0x000001 gives Result=0x000001. A=0x800000, B=0x7FFFFF gives 0x000001 (overflow-corrected). A=0x000005, B=0x000003 gives 0x000000 with Zero=1.
- NOR A=0x0F0F0F, B=0x00FF00 -> Result=0xF000F0, CarryOut=0, Overflow=0; OR of the same operands -> 0x0FFF0F.
- Backpressure: OutReady=0 for 10 cycles in DONE.
  - Result, flags and OutValid stay stable; InReady stays 0 while InValid is held high.
  - OutReady=1 gives one handshake, then IDLE.
  - The next op is accepted on the following cycle.
- Reset: ResetN=0 at BUSY cycle 12 -> all outputs 0 asynchronously, InReady=1. A new ADD after release yields a correct result with no stale carry.
